// File: rtl/cond_loop_gen.sv
// rtl/cond_loop_gen.sv - conditional loop sequencer with blocking/non-blocking call, join and yield
module cond_loop_gen #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 2**16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] limit_in,
    input  logic [WIDTH-1:0] step_in,
    input  logic [1:0]       mode_in,
    input  logic             run_req,
    output logic             run_busy,
    input  logic             start_req,
    output logic             start_busy,
    input  logic             join_req,
    output logic             join_busy,
    input  logic             yield_req,
    output logic             yield_busy,
    output logic [WIDTH-1:0] count_out,
    output logic [WIDTH-1:0] iter_out,
    output logic             done_out,
    output logic             overflow_out
);

    typedef enum logic [1:0] {IDLE, LOOP, PAUSE, DONE} state_t;

    localparam logic [63:0] MAX_ITER_W = 64'(MAX_ITER);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] count_d, iter_d;
    logic             overflow_d, done_d;
    logic             run_busy_d, start_busy_d, join_busy_d, yield_busy_d;
    logic             cond;
    logic             iter_hit;

    always_comb begin
        case (mode_q)
            2'd0:    cond = count_out < limit_q;
            2'd1:    cond = count_out != limit_q;
            2'd2:    cond = $signed(count_out) < $signed(limit_q);
            default: cond = count_out <= limit_q;
        endcase
    end

    assign iter_hit = 64'(iter_out) >= MAX_ITER_W;

    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        step_d       = step_q;
        mode_d       = mode_q;
        count_d      = count_out;
        iter_d       = iter_out;
        overflow_d   = overflow_out;
        done_d       = 1'b0;
        run_busy_d   = run_busy;
        start_busy_d = 1'b0;
        join_busy_d  = join_busy;
        yield_busy_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_req || start_req) begin
                    limit_d      = limit_in;
                    step_d       = step_in;
                    mode_d       = mode_in;
                    count_d      = '0;
                    iter_d       = '0;
                    overflow_d   = 1'b0;
                    run_busy_d   = run_req;
                    start_busy_d = !run_req;
                    state_d      = LOOP;
                end
            end
            LOOP, PAUSE: begin
                if (join_req) begin
                    join_busy_d = 1'b1;
                end
                // A PAUSE cycle with yield low evaluates like LOOP, so the stall
                // equals exactly the number of cycles yield was held.
                if (yield_req) begin
                    yield_busy_d = 1'b1;
                    state_d      = PAUSE;
                end else if (iter_hit) begin
                    overflow_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else if (cond) begin
                    count_d = count_out + step_q;
                    iter_d  = iter_out + 1'b1;
                    state_d = LOOP;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                run_busy_d  = 1'b0;
                join_busy_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            limit_q      <= '0;
            step_q       <= '0;
            mode_q       <= '0;
            count_out    <= '0;
            iter_out     <= '0;
            overflow_out <= 1'b0;
            done_out     <= 1'b0;
            run_busy     <= 1'b0;
            start_busy   <= 1'b0;
            join_busy    <= 1'b0;
            yield_busy   <= 1'b0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            step_q       <= step_d;
            mode_q       <= mode_d;
            count_out    <= count_d;
            iter_out     <= iter_d;
            overflow_out <= overflow_d;
            done_out     <= done_d;
            run_busy     <= run_busy_d;
            start_busy   <= start_busy_d;
            join_busy    <= join_busy_d;
            yield_busy   <= yield_busy_d;
        end
    end

endmodule

// File: tb/tb_cond_loop_gen.sv
// tb/tb_cond_loop_gen.sv - scoreboard bench for cond_loop_gen
module tb_cond_loop_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] limit_in = '0;
    logic [7:0] step_in = '0;
    logic [1:0] mode_in = '0;
    logic       run_req = 1'b0, start_req = 1'b0, join_req = 1'b0, yield_req = 1'b0;

    logic       run_busy, start_busy, join_busy, yield_busy, done_out, overflow_out;
    logic [7:0] count_out, iter_out;
    logic       o_run_busy, o_start_busy, o_join_busy, o_yield_busy, o_done, o_ovf;
    logic [7:0] o_count, o_iter;

    cond_loop_gen #(.WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .limit_in(limit_in), .step_in(step_in), .mode_in(mode_in),
        .run_req(run_req), .run_busy(run_busy), .start_req(start_req), .start_busy(start_busy),
        .join_req(join_req), .join_busy(join_busy), .yield_req(yield_req), .yield_busy(yield_busy),
        .count_out(count_out), .iter_out(iter_out), .done_out(done_out), .overflow_out(overflow_out)
    );

    cond_loop_gen #(.WIDTH(8), .MAX_ITER(16)) u_ovf (
        .clk(clk), .reset(reset), .limit_in(limit_in), .step_in(step_in), .mode_in(mode_in),
        .run_req(run_req), .run_busy(o_run_busy), .start_req(start_req), .start_busy(o_start_busy),
        .join_req(join_req), .join_busy(o_join_busy), .yield_req(yield_req), .yield_busy(o_yield_busy),
        .count_out(o_count), .iter_out(o_iter), .done_out(o_done), .overflow_out(o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] count;
        logic [7:0] iter;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every completion pulse of the main instance is matched against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done_out) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("done_cycle", cyc, e.cyc);
                check_eq("done_count", count_out, e.count);
                check_eq("done_iter", iter_out, e.iter);
                check_eq("done_ovf", overflow_out, e.ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input bit is_run, input logic [7:0] lim, input logic [7:0] stp,
                          input logic [1:0] md);
        limit_in  = lim;
        step_in   = stp;
        mode_in   = md;
        run_req   = is_run;
        start_req = !is_run;
        tick();
        run_req   = 1'b0;
        start_req = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 0);
        tick();
    endtask

    initial begin
        int t;
        int ny;
        int n;

        // reset with a run request held; it must not be accepted
        run_req = 1'b1;
        repeat (3) tick();
        reset   = 1'b0;
        run_req = 1'b0;
        tick();
        check_eq("rst_count", count_out, 0);
        check_eq("rst_iter", iter_out, 0);
        check_eq("rst_run_busy", run_busy, 0);
        check_eq("rst_done", done_out, 0);
        check_eq("rst_busy_flags", {start_busy, join_busy, yield_busy, overflow_out}, 0);

        // blocking run, limit 5
        t = cyc;
        sb.push_back('{t + 7, 8'd5, 8'd5, 1'b0});
        launch(1'b1, 8'd5, 8'd1, 2'd0);
        for (int j = 1; j <= 8; j++) begin
            check_eq($sformatf("run_busy_T%0d", j), run_busy, (j <= 7) ? 1 : 0);
            tick();
        end
        wait_drain(20);
        check_eq("idle_hold_count", count_out, 5);

        // signed compare against negative limit: immediate finish
        t = cyc;
        sb.push_back('{t + 2, 8'd0, 8'd0, 1'b0});
        launch(1'b0, 8'hF0, 8'd1, 2'd2);
        check_eq("start_busy_T1", start_busy, 1);
        check_eq("run_busy_on_start", run_busy, 0);
        tick();
        check_eq("start_busy_T2", start_busy, 0);
        wait_drain(10);

        // same limit unsigned: 240 iterations
        t = cyc;
        sb.push_back('{t + 242, 8'd240, 8'd240, 1'b0});
        launch(1'b0, 8'hF0, 8'd1, 2'd0);
        wait_drain(300);

        // run with a 3-cycle yield mid-loop
        t = cyc;
        sb.push_back('{t + 15, 8'd10, 8'd10, 1'b0});
        launch(1'b1, 8'd10, 8'd1, 2'd0);
        ny = 0;
        for (int i = 0; i < 16; i++) begin
            yield_req = (i >= 2 && i < 5);
            tick();
            if (yield_busy) ny++;
        end
        yield_req = 1'b0;
        check_eq("yield_busy_cycles", ny, 3);
        wait_drain(20);

        // yield in IDLE is ignored
        yield_req = 1'b1;
        tick();
        yield_req = 1'b0;
        check_eq("yield_idle", yield_busy, 0);

        // start then join; a run request mid-loop is ignored
        t = cyc;
        sb.push_back('{t + 6, 8'd4, 8'd4, 1'b0});
        launch(1'b0, 8'd4, 8'd1, 2'd0);
        join_req = 1'b1;
        run_req  = 1'b1;
        tick();
        join_req = 1'b0;
        run_req  = 1'b0;
        check_eq("join_busy_set", join_busy, 1);
        check_eq("run_ignored", run_busy, 0);
        repeat (4) tick();
        check_eq("join_busy_done", join_busy, 1);
        tick();
        check_eq("join_busy_clear", join_busy, 0);
        join_req = 1'b1;
        tick();
        join_req = 1'b0;
        check_eq("join_idle", join_busy, 0);
        repeat (3) tick();
        check_eq("sb_empty_mid", sb.size(), 0);

        // iteration ceiling on the MAX_ITER=16 instance; main instance keeps looping
        t = cyc;
        launch(1'b0, 8'd7, 8'd2, 2'd1);
        check_eq("ovf_start_busy", o_start_busy, 1);
        n = 0;
        while (!o_done && n < 40) begin
            tick();
            n++;
        end
        check_eq("ovf_done_cycle", cyc, t + 18);
        check_eq("ovf_iter", o_iter, 16);
        check_eq("ovf_count", o_count, 32);
        check_eq("ovf_flag", o_ovf, 1);
        tick();
        check_eq("ovf_hold", o_ovf, 1);
        check_eq("main_running", (iter_out != 0) ? 1 : 0, 1);

        // reset mid-loop with run request held
        reset   = 1'b1;
        run_req = 1'b1;
        tick();
        check_eq("mrst_count", count_out, 0);
        check_eq("mrst_iter", iter_out, 0);
        check_eq("mrst_busy", {run_busy, start_busy, join_busy, yield_busy, done_out, overflow_out}, 0);
        tick();
        reset   = 1'b0;
        run_req = 1'b0;
        tick();
        check_eq("mrst_run_not_accepted", run_busy, 0);
        repeat (3) tick();
        check_eq("mrst_still_idle", iter_out, 0);
        check_eq("sb_empty_end", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_loop_gen.md
COND_LOOP_GEN -- requirements
Module: cond_loop_gen

Interface
REQ-001 Parameter WIDTH, default 32, width of the counter, limit, step and iteration datapath.
REQ-002 Parameter MAX_ITER, default 2**16, iteration ceiling that forces loop termination.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 limit_in  in  WIDTH  loop bound, latched at accept.
REQ-006 step_in  in  WIDTH  increment per iteration, latched at accept.
REQ-007 mode_in  in  2  condition select, latched at accept: 0 unsigned <, 1 !=, 2 signed <, 3 unsigned <=.
REQ-008 run_req / run_busy  in / out  1 / 1  blocking loop call.
REQ-009 start_req / start_busy  in / out  1 / 1  non-blocking loop spawn.
REQ-010 join_req / join_busy  in / out  1 / 1  wait for the active loop to finish.
REQ-011 yield_req / yield_busy  in / out  1 / 1  pause the active loop.
REQ-012 count_out  out  WIDTH  current counter value.
REQ-013 iter_out  out  WIDTH  completed iteration count.
REQ-014 done_out  out  1  one-cycle completion pulse.
REQ-015 overflow_out  out  1  sticky flag: last loop ended on MAX_ITER.

Function
REQ-016 States SHALL be IDLE, LOOP, PAUSE and DONE; all outputs SHALL be registered.
REQ-017 In IDLE, run_req or start_req high SHALL be accepted: latch limit/step/mode, clear count_out, iter_out and overflow_out, go to LOOP; run_req has priority when both are high.
REQ-018 start_busy SHALL be high for exactly the one cycle after a start accept, and low otherwise.
REQ-019 run_busy SHALL be high from the cycle after a run accept through the DONE cycle inclusive.
REQ-020 Requests arriving in LOOP, PAUSE or DONE (run/start) SHALL be ignored.
REQ-021 Each LOOP cycle with yield_req low and the condition true on (count_out, latched limit) SHALL advance: count_out += step modulo 2**WIDTH, iter_out += 1.
REQ-022 Condition false in LOOP SHALL go to DONE with no advance that cycle.
REQ-023 iter_out reaching MAX_ITER SHALL go to DONE and set overflow_out, even if the condition is still true.
REQ-024 Each LOOP or PAUSE cycle with yield_req high SHALL not advance, and SHALL place the block in PAUSE the next cycle.
REQ-025 PAUSE SHALL return to LOOP on the first cycle yield_req is low; the stall count SHALL equal the number of active cycles yield_req is high.
REQ-026 yield_busy SHALL be high exactly while the state is PAUSE; yield_req in IDLE or DONE SHALL be ignored.
REQ-027 join_req high while the state is not IDLE SHALL set join_busy the next cycle; join_busy SHALL clear on the DONE-to-IDLE transition.
REQ-028 join_req in IDLE SHALL leave join_busy low.
REQ-029 done_out SHALL be high for exactly the DONE cycle; DONE SHALL always return to IDLE next cycle.
REQ-030 count_out, iter_out and overflow_out SHALL hold their final values in IDLE until the next accept.
REQ-031 Latency, N iterations, accept at cycle T: DONE at T+2+N plus yield stall cycles; IDLE the following cycle.

Reset
REQ-032 While reset is high, the next state SHALL be IDLE and all outputs SHALL be 0, including while a loop is in progress.
REQ-033 Requests sampled in the same cycle as reset SHALL be discarded.

Verification
REQ-034 WIDTH=8; run: limit 5, step 1, mode 0, accept at T -> run_busy high T+1..T+7, done_out high at T+7, count_out 5, iter_out 5, overflow_out 0.
REQ-035 WIDTH=8, MAX_ITER=16; start: limit 7, step 2, mode 1 -> start_busy 1 cycle, loop ends on the ceiling, iter_out 16, count_out 32, overflow_out 1.
REQ-036 WIDTH=8; start: mode 2, limit 8'hF0, step 1 -> no advance, done_out at T+2, iter_out 0; the same input with mode 0 -> iter_out 240.
REQ-037 Run with limit 10, step 1, mode 0; yield_req held 3 cycles mid-loop -> yield_busy high 3 cycles, done_out delayed 3 cycles to T+15, iter_out 10.
REQ-038 Start with limit 4, then join_req pulsed -> join_busy high until the DONE-to-IDLE transition; run_req during the loop is ignored; join_req in IDLE -> join_busy stays 0.
REQ-039 Reset asserted mid-loop -> next cycle IDLE, all outputs 0; a run_req held during reset is not accepted.
